// File: rtl/ibus_responder_if.sv
// Instruction-bus handshake between fetch (master) and the instruction responder (slave).
interface ibus_responder_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        iresp_err;
    logic        iresp_ready;
    logic        flush;

    modport master (
        output ireq_valid, ireq_addr, iresp_ready, flush,
        input  ireq_ready, iresp_valid, iresp_data, iresp_err
    );

    modport slave (
        input  ireq_valid, ireq_addr, iresp_ready, flush,
        output ireq_ready, iresp_valid, iresp_data, iresp_err
    );
endinterface

// File: rtl/ibus_responder.sv
// Memory-side instruction responder: one outstanding fetch, fixed latency, held response,
// redirect flush and an independent preload write port into the instruction store.
module ibus_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    ibus_responder_if.slave bus,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          req_err;
    logic [29:0]   off_word;
    logic [AW-1:0] idx;

    assign bus.ireq_ready  = !bus.flush &&
                             (state == IDLE || (state == RESP && bus.iresp_ready));
    assign accept          = bus.ireq_valid && bus.ireq_ready;

    // Word offset from the full 32-bit wrapping subtraction, so addresses below BASE_ADDR land out of range.
    assign off_word        = 30'((bus.ireq_addr - BASE_ADDR) >> 2);
    assign idx             = off_word[AW-1:0];
    assign req_err         = (bus.ireq_addr[1:0] != 2'b00) || ({2'b00, off_word} >= DEPTH);

    assign bus.iresp_valid = (state == RESP);
    assign bus.iresp_data  = resp_data;
    assign bus.iresp_err   = resp_err;

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // The response register samples mem with a non-blocking read, so a same-edge preload returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (accept) begin
            resp_err  <= req_err;
            resp_data <= req_err ? '0 : mem[idx];
            if (LATENCY == 1) begin
                state <= RESP;
                cnt   <= '0;
            end else begin
                state <= WAIT;
                cnt   <= CNT_INIT;
            end
        end else begin
            case (state)
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.iresp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder with a LATENCY=1 and a LATENCY=3 instance; responses checked against a queue.
module tb_ibus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    ibus_responder_if bus1();
    ibus_responder_if bus3();

    ibus_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    ibus_responder #(.DEPTH(1024), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    logic [31:0] model [1024];
    logic [32:0] q1 [$];
    logic [32:0] q3 [$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Negedge scoreboard: a handshaken response pops the queue; any valid with nothing outstanding is an error.
    task automatic monitor();
        logic [32:0] e;
        if (bus1.iresp_valid) begin
            if (q1.size() == 0) chk("l1_spurious_valid", 33'(bus1.iresp_valid), 33'd0);
            else if (bus1.iresp_ready && !bus1.flush) begin
                e = q1.pop_front();
                chk("l1_resp", {bus1.iresp_err, bus1.iresp_data}, e);
            end
        end
        if (bus3.iresp_valid) begin
            if (q3.size() == 0) chk("l3_spurious_valid", 33'(bus3.iresp_valid), 33'd0);
            else if (bus3.iresp_ready && !bus3.flush) begin
                e = q3.pop_front();
                chk("l3_resp", {bus3.iresp_err, bus3.iresp_data}, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset     = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        bus1.ireq_valid = 1'b0; bus1.ireq_addr = '0; bus1.iresp_ready = 1'b1; bus1.flush = 1'b0;
        bus3.ireq_valid = 1'b0; bus3.ireq_addr = '0; bus3.iresp_ready = 1'b1; bus3.flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("l1_reset_valid", 33'(bus1.iresp_valid), 33'd0);
        chk("l1_reset_resp", {bus1.iresp_err, bus1.iresp_data}, 33'd0);
        chk("l1_reset_ready", 33'(bus1.ireq_ready), 33'd1);
        chk("l3_reset_valid", 33'(bus3.iresp_valid), 33'd0);
        chk("l3_reset_ready", 33'(bus3.ireq_ready), 33'd1);

        // Preload words 0..3 and the last word of the store.
        model[0] = 32'h2008_0001; model[1] = 32'h2009_0002;
        model[2] = 32'h0109_5020; model[3] = 32'h1000_FFFF;
        model[1023] = 32'hCAFE_F00D;
        load_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_addr = (i == 4) ? 10'd1023 : 10'(i);
            load_data = model[load_addr];
            tick();
        end
        load_en = 1'b0;

        // LATENCY=1 back-to-back fetch of words 0..3.
        bus1.ireq_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus1.ireq_addr = 32'(4 * i);
            settle();
            chk("l1_b2b_ready", 33'(bus1.ireq_ready), 33'd1);
            q1.push_back({1'b0, model[i]});
            tick();
        end
        bus1.ireq_valid = 1'b0;
        tick();
        chk("l1_b2b_drained", 33'(q1.size()), 33'd0);

        // LATENCY=3 single fetch of 0x4.
        bus3.ireq_valid = 1'b1;
        bus3.ireq_addr  = 32'h4;
        settle();
        chk("l3_lat_ready", 33'(bus3.ireq_ready), 33'd1);
        q3.push_back({1'b0, model[1]});
        tick();
        bus3.ireq_valid = 1'b0;
        settle();
        chk("l3_lat_n1_valid", 33'(bus3.iresp_valid), 33'd0);
        tick();
        settle();
        chk("l3_lat_n2_valid", 33'(bus3.iresp_valid), 33'd0);
        tick();
        settle();
        chk("l3_lat_n3_valid", 33'(bus3.iresp_valid), 33'd1);
        chk("l3_lat_n3_data", {bus3.iresp_err, bus3.iresp_data}, {1'b0, 32'h2009_0002});
        tick();
        chk("l3_lat_drained", 33'(q3.size()), 33'd0);

        // Stall on LATENCY=1: held response survives a preload to the same word.
        bus1.iresp_ready = 1'b0;
        bus1.ireq_valid  = 1'b1;
        bus1.ireq_addr   = 32'hC;
        settle();
        q1.push_back({1'b0, model[3]});
        tick();
        bus1.ireq_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            load_en   = (i == 0);
            load_addr = 10'd3;
            load_data = 32'h1234_5678;
            settle();
            chk("l1_stall_valid", 33'(bus1.iresp_valid), 33'd1);
            chk("l1_stall_data", {bus1.iresp_err, bus1.iresp_data}, {1'b0, 32'h1000_FFFF});
            chk("l1_stall_ready", 33'(bus1.ireq_ready), 33'd0);
            tick();
        end
        model[3] = 32'h1234_5678;
        load_en = 1'b0;
        bus1.iresp_ready = 1'b1;
        settle();
        chk("l1_unstall_ready", 33'(bus1.ireq_ready), 33'd1);
        q1.push_back({1'b0, model[2]});
        tick();
        bus1.ireq_valid = 1'b0;
        tick();
        chk("l1_stall_drained", 33'(q1.size()), 33'd0);

        // Error and boundary addresses on LATENCY=1.
        bus1.ireq_valid = 1'b1;
        bus1.ireq_addr = 32'h0000_0006; q1.push_back({1'b1, 32'h0}); tick();
        bus1.ireq_addr = 32'h0000_1000; q1.push_back({1'b1, 32'h0}); tick();
        bus1.ireq_addr = 32'hFFFF_FFFC; q1.push_back({1'b1, 32'h0}); tick();
        bus1.ireq_addr = 32'h0000_0FFC; q1.push_back({1'b0, 32'hCAFE_F00D}); tick();
        bus1.ireq_valid = 1'b0;
        tick();
        chk("l1_err_drained", 33'(q1.size()), 33'd0);

        // Flush during WAIT, then flush held against a pending request.
        bus3.ireq_valid = 1'b1;
        bus3.ireq_addr  = 32'h8;
        tick();
        bus3.flush     = 1'b1;
        bus3.ireq_addr = 32'hC;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("l3_flush_ready", 33'(bus3.ireq_ready), 33'd0);
            tick();
        end
        bus3.flush      = 1'b0;
        bus3.ireq_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("l3_flush_no_valid", 33'(bus3.iresp_valid), 33'd0);
            tick();
        end
        bus3.ireq_valid = 1'b1;
        bus3.ireq_addr  = 32'h0;
        q3.push_back({1'b0, model[0]});
        tick();
        bus3.ireq_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("l3_post_flush_drained", 33'(q3.size()), 33'd0);

        // Reset while LATENCY=3 request is in WAIT: the request is lost.
        bus3.ireq_valid = 1'b1;
        bus3.ireq_addr  = 32'h4;
        tick();
        bus3.ireq_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("l3_reset_no_valid", 33'(bus3.iresp_valid), 33'd0);
            tick();
        end

        // Load/accept collision on word 2 returns the old word; the next read sees the new one.
        bus1.ireq_valid = 1'b1;
        bus1.ireq_addr  = 32'h8;
        load_en   = 1'b1;
        load_addr = 10'd2;
        load_data = 32'hDEAD_BEEF;
        q1.push_back({1'b0, model[2]});
        model[2] = 32'hDEAD_BEEF;
        tick();
        load_en = 1'b0;
        q1.push_back({1'b0, model[2]});
        tick();
        bus1.ireq_valid = 1'b0;
        tick();
        chk("l1_collide_drained", 33'(q1.size()), 33'd0);
        chk("l3_final_drained", 33'(q3.size()), 33'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
